// File: rtl/cdclib_pkg.sv
// rtl/cdclib_pkg.sv - shared types and helpers for the cdclib sync filter
// Contents:
//   cdclib_flt_state_e : per-bit filter state (STABLE = 1'b0, QUALIFY = 1'b1)
//   cdclib_clog2       : ceiling log2, used to size the qualify counters
package cdclib_pkg;

    typedef enum logic {
        CDCLIB_FLT_STABLE  = 1'b0,
        CDCLIB_FLT_QUALIFY = 1'b1
    } cdclib_flt_state_e;

    function automatic int cdclib_clog2(input int value);
        int result;
        int acc;
        result = 0;
        acc    = 1;
        while (acc < value) begin
            acc    = acc * 2;
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/cdclib_sync_filter_bit.sv
// rtl/cdclib_sync_filter_bit.sv - one-bit stability qualifier with rise/fall pulses
// Ports:
//   clk         : destination-domain clock
//   rst_n       : synchronous active-low reset
//   data_in     : synchronized input bit
//   data_out    : filtered level, registered
//   rise_pulse  : one-cycle pulse on accepted 0->1, registered
//   fall_pulse  : one-cycle pulse on accepted 1->0, registered
//   accept_next : combinational, high in the cycle before a pulse appears
module cdclib_sync_filter_bit
    import cdclib_pkg::*;
#(
    parameter logic RESET_VAL  = 1'b0,
    parameter int   FILTER_CNT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic data_in,
    output logic data_out,
    output logic rise_pulse,
    output logic fall_pulse,
    output logic accept_next
);

    localparam int                CNT_W    = cdclib_clog2(FILTER_CNT) + 1;
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(FILTER_CNT - 1);

    cdclib_flt_state_e state;
    logic [CNT_W-1:0]  cnt;
    logic              mismatch;

    assign mismatch = (data_in != data_out);

    // A change is accepted either immediately (filter bypassed) or once the
    // mismatch has been seen on the final qualify cycle.
    always_comb begin
        accept_next = 1'b0;
        if (mismatch) begin
            if (state == CDCLIB_FLT_STABLE)
                accept_next = (FILTER_CNT == 1);
            else
                accept_next = (cnt == LAST_CNT);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= CDCLIB_FLT_STABLE;
            cnt        <= '0;
            data_out   <= RESET_VAL;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
        end else begin
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
            if (accept_next) begin
                data_out   <= data_in;
                rise_pulse <= data_in;
                fall_pulse <= ~data_in;
                state      <= CDCLIB_FLT_STABLE;
                cnt        <= '0;
            end else begin
                case (state)
                    CDCLIB_FLT_STABLE: begin
                        if (mismatch) begin
                            state <= CDCLIB_FLT_QUALIFY;
                            cnt   <= CNT_W'(1);
                        end else begin
                            cnt <= '0;
                        end
                    end
                    CDCLIB_FLT_QUALIFY: begin
                        if (!mismatch) begin
                            // Input fell back before qualifying: treat as a glitch.
                            state <= CDCLIB_FLT_STABLE;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    default: begin
                        state <= CDCLIB_FLT_STABLE;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/cdclib_sync_filter.sv
// rtl/cdclib_sync_filter.sv - per-bit stability filter and edge detector after a bit synchronizer
// Ports:
//   clk        : destination-domain clock
//   rst_n      : synchronous active-low reset
//   data_in    : DWIDTH synchronized bits
//   data_out   : DWIDTH filtered levels, registered
//   rise_pulse : DWIDTH one-cycle 0->1 pulses, registered
//   fall_pulse : DWIDTH one-cycle 1->0 pulses, registered
//   change_any : registered OR of all pulses, aligned with them
module cdclib_sync_filter
    import cdclib_pkg::*;
#(
    parameter int   DWIDTH     = 1,
    parameter logic RESET_VAL  = 1'b0,
    parameter int   FILTER_CNT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DWIDTH-1:0] data_in,
    output logic [DWIDTH-1:0] data_out,
    output logic [DWIDTH-1:0] rise_pulse,
    output logic [DWIDTH-1:0] fall_pulse,
    output logic              change_any
);

    logic [DWIDTH-1:0] accept_vec;

    genvar i;
    generate
        for (i = 0; i < DWIDTH; i++) begin : g_bit
            cdclib_sync_filter_bit #(
                .RESET_VAL  (RESET_VAL),
                .FILTER_CNT (FILTER_CNT)
            ) u_bit (
                .clk         (clk),
                .rst_n       (rst_n),
                .data_in     (data_in[i]),
                .data_out    (data_out[i]),
                .rise_pulse  (rise_pulse[i]),
                .fall_pulse  (fall_pulse[i]),
                .accept_next (accept_vec[i])
            );
        end
    endgenerate

    // Registered from the same accept terms as the pulses so it lands in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst_n)
            change_any <= 1'b0;
        else
            change_any <= |accept_vec;
    end

endmodule

// File: tb/tb_cdclib_sync_filter.sv
// tb/tb_cdclib_sync_filter.sv - self-checking bench for cdclib_sync_filter
module tb_cdclib_sync_filter;

    typedef struct packed {
        logic [3:0] d;
        logic [3:0] r;
        logic [3:0] f;
        logic       c;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] data_in = 4'h0;

    // a: RESET_VAL=1, FILTER_CNT=4   b: RESET_VAL=0, FILTER_CNT=4   c: RESET_VAL=0, FILTER_CNT=1
    logic [3:0] a_d, a_r, a_f, b_d, b_r, b_f, c_d, c_r, c_f;
    logic       a_c, b_c, c_c;

    cdclib_sync_filter #(.DWIDTH(4), .RESET_VAL(1'b1), .FILTER_CNT(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .data_in(data_in),
        .data_out(a_d), .rise_pulse(a_r), .fall_pulse(a_f), .change_any(a_c));
    cdclib_sync_filter #(.DWIDTH(4), .RESET_VAL(1'b0), .FILTER_CNT(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .data_in(data_in),
        .data_out(b_d), .rise_pulse(b_r), .fall_pulse(b_f), .change_any(b_c));
    cdclib_sync_filter #(.DWIDTH(4), .RESET_VAL(1'b0), .FILTER_CNT(1)) dut_c (
        .clk(clk), .rst_n(rst_n), .data_in(data_in),
        .data_out(c_d), .rise_pulse(c_r), .fall_pulse(c_f), .change_any(c_c));

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int b_chg_count = 0;

    exp_t q_a[$], q_b[$], q_c[$];

    // Reference model: per bit, length of the current run of samples that
    // disagree with the filtered level; accept when the run reaches FILTER_CNT.
    logic [3:0] m_lvl[3];
    int         m_run[3][4];

    function automatic exp_t model_step(input int k, input int fc, input logic rv);
        exp_t e;
        e = '0;
        if (!rst_n) begin
            m_lvl[k] = rv ? 4'hF : 4'h0;
            for (int i = 0; i < 4; i++) m_run[k][i] = 0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (data_in[i] != m_lvl[k][i]) begin
                    m_run[k][i] = m_run[k][i] + 1;
                    if (m_run[k][i] >= fc) begin
                        m_lvl[k][i] = data_in[i];
                        if (data_in[i]) e.r[i] = 1'b1;
                        else            e.f[i] = 1'b1;
                        m_run[k][i] = 0;
                    end
                end else begin
                    m_run[k][i] = 0;
                end
            end
        end
        e.d = m_lvl[k];
        e.c = |(e.r | e.f);
        return e;
    endfunction

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic compare_inst(input string nm, input exp_t e,
                                input logic [3:0] d, input logic [3:0] r,
                                input logic [3:0] f, input logic c);
        check({nm, ".data_out"},   d, e.d);
        check({nm, ".rise_pulse"}, r, e.r);
        check({nm, ".fall_pulse"}, f, e.f);
        check({nm, ".change_any"}, {3'b0, c}, {3'b0, e.c});
    endtask

    // Drive one cycle of inputs, push model predictions, clock, then pop and compare.
    task automatic step(input logic rst_v, input logic [3:0] din);
        exp_t ea, eb, ec;
        rst_n   = rst_v;
        data_in = din;
        q_a.push_back(model_step(0, 4, 1'b1));
        q_b.push_back(model_step(1, 4, 1'b0));
        q_c.push_back(model_step(2, 1, 1'b0));
        @(posedge clk);
        #1;
        ea = q_a.pop_front();
        eb = q_b.pop_front();
        ec = q_c.pop_front();
        compare_inst("a", ea, a_d, a_r, a_f, a_c);
        compare_inst("b", eb, b_d, b_r, b_f, b_c);
        compare_inst("c", ec, c_d, c_r, c_f, c_c);
        if (b_c) b_chg_count++;
    endtask

    task automatic hold(input logic [3:0] din, input int n);
        for (int i = 0; i < n; i++) step(1'b1, din);
    endtask

    initial begin
        // Reset with random data; RESET_VAL=1 instance must show 4'hF.
        for (int i = 0; i < 3; i++) step(1'b0, 4'($urandom_range(0, 15)));
        check("reset_a_level", a_d, 4'hF);
        check("reset_b_level", b_d, 4'h0);

        // Release with data matching the reset level of instance a.
        hold(4'hF, 20);
        hold(4'h0, 10);

        // Accept: bit 0 rises and is held; exactly one change_any on b.
        b_chg_count = 0;
        hold(4'b0001, 8);
        check("accept_b_change_count", 4'(b_chg_count), 4'd1);
        check("accept_b_level", b_d, 4'b0001);

        // Glitch reject on bit 1: 3-cycle, then 1-cycle excursion.
        b_chg_count = 0;
        hold(4'b0011, 3);
        hold(4'b0001, 6);
        hold(4'b0011, 1);
        hold(4'b0001, 6);
        check("glitch_b_change_count", 4'(b_chg_count), 4'd0);
        check("glitch_b_level", b_d, 4'b0001);

        // Bypass instance: bit 2 rises, falls, then toggles every cycle.
        hold(4'b0101, 3);
        hold(4'b0001, 3);
        for (int i = 0; i < 8; i++) step(1'b1, (i % 2 == 0) ? 4'b0101 : 4'b0001);
        hold(4'b0001, 6);

        // Multi-bit: bit 0 falls and bit 3 rises at the same edge.
        b_chg_count = 0;
        hold(4'b1000, 6);
        check("multi_b_change_count", 4'(b_chg_count), 4'd1);
        check("multi_b_level", b_d, 4'b1000);

        // Reset abort mid-qualification.
        hold(4'b0110, 2);
        step(1'b0, 4'b0110);
        check("abort_b_level", b_d, 4'h0);
        check("abort_a_level", a_d, 4'hF);
        b_chg_count = 0;
        hold(4'h0, 6);
        check("abort_b_change_count", 4'(b_chg_count), 4'd0);

        // Random hold lengths for broader coverage.
        for (int i = 0; i < 25; i++) hold(4'($urandom_range(0, 15)), $urandom_range(1, 6));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
